// File: rtl/pe_array_param_if.sv
// rtl/pe_array_param_if.sv - control, operand and result bundle for pe_array_param
interface pe_array_param_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 36,
    parameter int KW     = 16
);
    localparam int IW = $clog2(ROWS);

    logic                     start;
    logic [KW-1:0]            k_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*DATA_W-1:0]   act_in;
    logic [COLS*DATA_W-1:0]   wgt_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [COLS*ACC_W-1:0]    out_row;
    logic [IW-1:0]            out_row_idx;
    logic                     busy;
    logic                     done;

    modport master (
        output start, k_len, in_valid, act_in, wgt_in, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, act_in, wgt_in, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, busy, done
    );
endinterface

// File: rtl/pe_array_param.sv
// rtl/pe_array_param.sv - output-stationary systolic MAC array computing C = A x W
module pe_array_param #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 36,
    parameter int KW       = 16,
    parameter int SATURATE = 0
) (
    input  logic            clk,
    input  logic            rst,
    pe_array_param_if.slave bus
);
    localparam int IW        = $clog2(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam int FW        = $clog2(FLUSH_LEN + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;
    state_t state, state_n;

    logic [KW-1:0] k_len_q;
    logic [KW-1:0] k_cnt;
    logic [FW-1:0] flush_cnt;
    logic [IW-1:0] row_idx;
    logic          done_q;

    logic clr, feed_beat, advance, last_beat, last_flush, row_take, last_row;

    assign clr        = (state == IDLE) && bus.start;
    assign feed_beat  = (state == FEED) && bus.in_valid;
    assign advance    = feed_beat || (state == FLUSH);
    assign last_beat  = feed_beat && ((k_cnt + KW'(1)) == k_len_q);
    assign last_flush = (state == FLUSH) && (flush_cnt == FW'(FLUSH_LEN - 1));
    assign row_take   = (state == DRAIN) && bus.out_ready;
    assign last_row   = (row_idx == IW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = (bus.k_len == '0) ? DRAIN : FEED;
            FEED:    if (last_beat) state_n = FLUSH;
            FLUSH:   if (last_flush) state_n = DRAIN;
            DRAIN:   if (row_take && last_row) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_len_q   <= '0;
            k_cnt     <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= row_take && last_row;
            if (clr) begin
                k_len_q   <= bus.k_len;
                k_cnt     <= '0;
                flush_cnt <= '0;
                row_idx   <= '0;
            end
            if (feed_beat)
                k_cnt <= k_cnt + KW'(1);
            if (state == FLUSH)
                flush_cnt <= flush_cnt + FW'(1);
            // The final row index is held so out_row keeps showing it in IDLE.
            if (row_take && !last_row)
                row_idx <= row_idx + IW'(1);
        end
    end

    logic signed [DATA_W-1:0] a_lane [ROWS];
    logic signed [DATA_W-1:0] w_lane [COLS];

    genvar gr, gc;

    // Only FEED injects real operands; FLUSH pushes zeros through the wavefront.
    for (gr = 0; gr < ROWS; gr++) begin : g_act_skew
        logic signed [DATA_W-1:0] inj;
        assign inj = (state == FEED) ? bus.act_in[gr*DATA_W +: DATA_W] : '0;
        if (gr == 0) begin : g_direct
            assign a_lane[gr] = inj;
        end else begin : g_delay
            logic signed [DATA_W-1:0] sk [gr];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sk <= '{default: '0};
                end else if (clr) begin
                    sk <= '{default: '0};
                end else if (advance) begin
                    sk[0] <= inj;
                    for (int s = 1; s < gr; s++) sk[s] <= sk[s-1];
                end
            end
            assign a_lane[gr] = sk[gr-1];
        end
    end

    for (gc = 0; gc < COLS; gc++) begin : g_wgt_skew
        logic signed [DATA_W-1:0] inj;
        assign inj = (state == FEED) ? bus.wgt_in[gc*DATA_W +: DATA_W] : '0;
        if (gc == 0) begin : g_direct
            assign w_lane[gc] = inj;
        end else begin : g_delay
            logic signed [DATA_W-1:0] sk [gc];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sk <= '{default: '0};
                end else if (clr) begin
                    sk <= '{default: '0};
                end else if (advance) begin
                    sk[0] <= inj;
                    for (int s = 1; s < gc; s++) sk[s] <= sk[s-1];
                end
            end
            assign w_lane[gc] = sk[gc-1];
        end
    end

    logic signed [DATA_W-1:0] a_reg [ROWS][COLS-1];
    logic signed [DATA_W-1:0] w_reg [ROWS-1][COLS];
    logic signed [ACC_W-1:0]  acc   [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_n [ROWS][COLS];
    logic signed [DATA_W-1:0] a_in  [ROWS][COLS];
    logic signed [DATA_W-1:0] w_in  [ROWS][COLS];

    for (gr = 0; gr < ROWS; gr++) begin : g_row
        for (gc = 0; gc < COLS; gc++) begin : g_pe
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W:0]      sum;

            if (gc == 0) begin : g_a_edge
                assign a_in[gr][gc] = a_lane[gr];
            end else begin : g_a_inner
                assign a_in[gr][gc] = a_reg[gr][gc-1];
            end
            if (gr == 0) begin : g_w_edge
                assign w_in[gr][gc] = w_lane[gc];
            end else begin : g_w_inner
                assign w_in[gr][gc] = w_reg[gr-1][gc];
            end

            assign prod = (2*DATA_W)'(a_in[gr][gc]) * (2*DATA_W)'(w_in[gr][gc]);
            // One guard bit exposes signed overflow of every single addition.
            assign sum  = (ACC_W+1)'(acc[gr][gc]) + (ACC_W+1)'(prod);
            assign acc_n[gr][gc] = (SATURATE != 0 && sum[ACC_W] != sum[ACC_W-1])
                                 ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                 : sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '{default: '0};
            a_reg <= '{default: '0};
            w_reg <= '{default: '0};
        end else if (clr) begin
            acc   <= '{default: '0};
            a_reg <= '{default: '0};
            w_reg <= '{default: '0};
        end else if (advance) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    acc[r][c] <= acc_n[r][c];
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS - 1; c++)
                    a_reg[r][c] <= a_in[r][c];
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    w_reg[r][c] <= w_in[r][c];
        end
    end

    assign bus.in_ready    = (state == FEED);
    assign bus.out_valid   = (state == DRAIN);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.out_row_idx = row_idx;

    for (gc = 0; gc < COLS; gc++) begin : g_out
        assign bus.out_row[gc*ACC_W +: ACC_W] = acc[row_idx][gc];
    end
endmodule

// File: doc/pe_array_param.md
PE_ARRAY_PARAM -- requirements
Module: pe_array_param

Interface
REQ-001 SHALL have parameter ROWS, default 8: array rows, i.e. the activation lanes; legal range 2..16.
REQ-002 SHALL have parameter COLS, default 8: array columns, i.e. the weight lanes; legal range 2..16.
REQ-003 SHALL have parameter DATA_W, default 16: signed operand width.
REQ-004 SHALL have parameter ACC_W, default 36: signed accumulator width; ACC_W >= 2*DATA_W.
REQ-005 SHALL have parameter KW, default 16: width of k_len.
REQ-006 SHALL have parameter SATURATE, default 0: 0 = accumulate with wrap-around; 1 = accumulate with signed saturation.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port start, input, 1 bit: begin one matrix-multiply operation.
REQ-010 SHALL have port k_len, input, KW bits: inner-dimension length K, sampled on accepted start.
REQ-011 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-012 SHALL have port in_ready, output, 1 bit: operand beat accepted when in_valid && in_ready.
REQ-013 SHALL have port act_in, input, ROWS*DATA_W bits: column k of A; row r at [r*DATA_W +: DATA_W].
REQ-014 SHALL have port wgt_in, input, COLS*DATA_W bits: row k of W; column c at [c*DATA_W +: DATA_W].
REQ-015 SHALL have port out_valid, output, 1 bit: result row valid.
REQ-016 SHALL have port out_ready, input, 1 bit: result row consumed when out_valid && out_ready.
REQ-017 SHALL have port out_row, output, COLS*ACC_W bits: C[out_row_idx][c] at [c*ACC_W +: ACC_W].
REQ-018 SHALL have port out_row_idx, output, $clog2(ROWS) bits: index of the current result row.
REQ-019 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse after the last row is consumed.

Function
REQ-021 SHALL compute C = A x W, where C[r][c] = sum over k of A[r][k]*W[k][c], with a signed DATA_W x DATA_W product sign-extended to ACC_W.
REQ-022 SHALL implement the FSM states IDLE, FEED, FLUSH and DRAIN.
REQ-023 IDLE: start with k_len>0 SHALL clear all accumulators, skew registers and PE registers, then go to FEED.
  - start with k_len==0 SHALL clear the accumulators and go directly to DRAIN.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 in_ready SHALL be 1 only in FEED.
  - in_valid outside FEED SHALL be ignored.
REQ-026 "Advance" SHALL mean (FEED && in_valid && in_ready) or any cycle in FLUSH; skew registers, PE registers and accumulators SHALL change only on an advance.
  - In FEED with in_valid low the whole array SHALL freeze.
REQ-027 Skew:
  - row r activation SHALL pass through r skew stages.
  - column c weight SHALL pass through c skew stages.
  - row 0 and column 0 SHALL have no delay.
REQ-028 On each advance, PE(r,c) SHALL perform all three of the following:
  - acc <= acc + a_in*w_in;
  - latch a_in and forward it to PE(r,c+1);
  - latch w_in and forward it to PE(r+1,c).
  Here a_in is the skewed act_in lane or the left neighbour's register, and w_in is the skewed wgt_in lane or the upper neighbour's register.
REQ-029 FEED SHALL exit to FLUSH on the k_len-th accepted beat.
  - FLUSH SHALL last exactly ROWS+COLS-2 cycles, injecting zero activations and zero weights.
  - After that, the FSM SHALL go to DRAIN.
REQ-030 SATURATE=0: additions SHALL wrap modulo 2^ACC_W.
REQ-031 SATURATE=1: on overflow the result SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - Clamping SHALL be evaluated on each addition.
REQ-032 DRAIN, on entry:
  - out_valid SHALL be 1, out_row_idx 0 and out_row = accumulator row 0.
  - Each out_valid && out_ready SHALL increment out_row_idx.
REQ-033 While out_valid && !out_ready, out_row and out_row_idx SHALL hold stable.
REQ-034 On the handshake of row ROWS-1, the block SHALL do all of the following:
  - deassert out_valid the next cycle;
  - pulse done for one cycle;
  - return to IDLE.
  In IDLE, out_row SHALL retain its last value.
REQ-035 Latency: the first out_valid SHALL occur one cycle after the last FLUSH cycle, i.e. ROWS+COLS-1 cycles after the last accepted beat.

Reset
REQ-036 While rst=1, asynchronously, the block SHALL set the following:
  - state IDLE;
  - in_ready=0, out_valid=0, busy=0, done=0;
  - out_row=0, out_row_idx=0;
  - all accumulators, skew registers and PE registers = 0.
REQ-037 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst falls SHALL behave as from power-up.

Verification
REQ-038 The bench SHALL cover the following directed scenarios at the default parameters unless stated otherwise:
  - Identity: k_len=8, A=I, W[k][c]=8k+c, in_valid held 1 -> rows r=0..7 output C[r][c]=8r+c; first out_valid 15 cycles after the last beat; done pulses once.
  - Input stalls: same data with in_valid toggled 1,0,1,0 -> results identical to Identity.
  - Backpressure: out_ready=0 for 5 cycles while out_row_idx=3 -> out_row and index stay constant; rows 4..7 then follow in order.
  - Saturation: ROWS=COLS=2, ACC_W=32, k_len=4, all operands -32768 ->
    - SATURATE=1 gives 0x7FFFFFFF in every element;
    - SATURATE=0 gives 0x00000000.
  - Reset in FLUSH: rst pulsed for 1 cycle -> all outputs 0, no done; a following Identity run passes.
  - Zero length: start with k_len=0 -> immediate DRAIN of 8 all-zero rows, then done; start during busy is ignored.
